// File: rtl/bht_predictor.sv
// Branch history table: 2^INDEX_BITS two-bit saturating counters, bimodal or
// gshare indexing, write-first forwarding from same-cycle updates, a sweeping
// flush FSM and a saturating mispredict counter.
module bht_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter int         PC_WIDTH   = 32,
  parameter int         GHR_BITS   = 6,
  parameter int         MODE       = 0,
  parameter logic [1:0] INIT_CTR   = 2'b00
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lookup_valid,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_valid,
  output logic                prediction,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_outcome,
  input  logic                flush,
  output logic                busy,
  output logic [15:0]         mispredict_cnt
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t                r_state;
  logic [INDEX_BITS-1:0] r_ptr;
  logic [1:0]            r_ctr [ENTRIES];
  logic [GHR_BITS-1:0]   r_ghr;
  logic                  r_pred_valid;
  logic                  r_pred;
  logic                  r_busy;
  logic [15:0]           r_mis_cnt;

  logic [INDEX_BITS-1:0] w_ghr_ext;
  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic                  w_idle;
  logic                  w_upd_en;
  logic [1:0]            w_up_ctr;
  logic [1:0]            w_up_new;
  logic [1:0]            w_lk_ctr;
  logic                  w_mis;
  logic [GHR_BITS-1:0]   w_ghr_next;
  logic                  w_unused_pc;

  // History only participates in gshare; bimodal sees a zero term.
  assign w_ghr_ext  = (MODE == 1) ? INDEX_BITS'(r_ghr) : '0;
  assign w_lk_idx   = lookup_pc[INDEX_BITS+1:2] ^ w_ghr_ext;
  assign w_up_idx   = update_pc[INDEX_BITS+1:2] ^ w_ghr_ext;
  assign w_idle     = (r_state == S_IDLE);
  assign w_upd_en   = update_valid && w_idle;
  assign w_up_ctr   = r_ctr[w_up_idx];
  assign w_up_new   = update_outcome ? ((w_up_ctr == 2'd3) ? 2'd3 : w_up_ctr + 2'd1)
                                     : ((w_up_ctr == 2'd0) ? 2'd0 : w_up_ctr - 2'd1);
  // Write-first: a lookup hitting the entry being updated sees the new value.
  assign w_lk_ctr   = (w_upd_en && (w_up_idx == w_lk_idx)) ? w_up_new : r_ctr[w_lk_idx];
  assign w_mis      = w_upd_en && (w_up_ctr[1] != update_outcome);
  assign w_ghr_next = GHR_BITS'({r_ghr, update_outcome});
  assign w_unused_pc = ^{lookup_pc, update_pc};

  assign pred_valid     = r_pred_valid;
  assign prediction     = r_pred;
  assign busy           = r_busy;
  assign mispredict_cnt = r_mis_cnt;

  // Flush FSM: sweep pointer walks every entry once, busy mirrors FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (flush) begin
          r_state <= S_FLUSH;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
        S_FLUSH: if (r_ptr == '1) begin
          r_state <= S_IDLE;
          r_ptr   <= '0;
          r_busy  <= 1'b0;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Counter table: sweep writes win over training; training only when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= INIT_CTR;
    end else if (r_state == S_FLUSH) begin
      r_ctr[r_ptr] <= INIT_CTR;
    end else if (w_upd_en) begin
      r_ctr[w_up_idx] <= w_up_new;
    end
  end

  // Global history: cleared on flush entry, shifted by accepted updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_ghr <= '0;
    else if (MODE != 1)        r_ghr <= '0;
    else if (w_idle && flush)  r_ghr <= '0;
    else if (w_upd_en)         r_ghr <= w_ghr_next;
  end

  // Registered prediction; a busy table answers not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred       <= 1'b0;
    end else begin
      r_pred_valid <= lookup_valid;
      r_pred       <= lookup_valid && w_idle && w_lk_ctr[1];
    end
  end

  // Saturating mispredict counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_mis_cnt <= '0;
    else if (w_mis && r_mis_cnt != '1)   r_mis_cnt <= r_mis_cnt + 16'd1;
  end
endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, log2 of table entries (range 2..10).
REQ-002 SHALL have parameter PC_WIDTH, default 32, branch address width.
REQ-003 SHALL have parameter GHR_BITS, default 6, global history length (1..INDEX_BITS).
REQ-004 SHALL have parameter MODE, default 0, index mode: 0 = bimodal, 1 = gshare.
REQ-005 SHALL have parameter INIT_CTR, default 2'b00, counter value loaded on reset and flush.
REQ-006 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port lookup_valid  input  1  predict request this cycle.
REQ-009 SHALL have port lookup_pc  input  PC_WIDTH  address of the branch being predicted.
REQ-010 SHALL have port pred_valid  output  1  registered; prediction valid.
REQ-011 SHALL have port prediction  output  1  registered; 1 = taken.
REQ-012 SHALL have port update_valid  input  1  branch resolved in EX this cycle.
REQ-013 SHALL have port update_pc  input  PC_WIDTH  address of the resolved branch.
REQ-014 SHALL have port update_outcome  input  1  actual outcome, 1 = taken.
REQ-015 SHALL have port flush  input  1  synchronous request to reinitialise the table.
REQ-016 SHALL have port busy  output  1  high while a flush sweep is in progress.
REQ-017 SHALL have port mispredict_cnt  output  16  saturating count of mispredicted updates.

Function
REQ-018 SHALL hold 2^INDEX_BITS 2-bit saturating counters; the predicted direction is counter bit 1.
REQ-019 SHALL compute base index = pc[INDEX_BITS+1:2]; MODE 1 XORs the base index with the zero-extended GHR.
REQ-020 SHALL register prediction and pred_valid one cycle after lookup_valid (latency 1); pred_valid is 0 in the cycle after lookup_valid = 0.
REQ-021 SHALL, on update_valid while not busy, increment the counter at the update index when outcome = 1 (saturating at 3) and decrement it when outcome = 0 (saturating at 0).
REQ-022 SHALL, in MODE 1, compute the update index with the GHR value before the update, then shift GHR <= {GHR[GHR_BITS-2:0], update_outcome}; MODE 0 SHALL leave GHR unused and held at 0.
REQ-023 SHALL forward a same-cycle update to a lookup with an equal index: the prediction reflects the post-update counter (write-first).
REQ-024 SHALL increment mispredict_cnt on each accepted update where the pre-update counter bit 1 differs from update_outcome, saturating at 16'hFFFF.
REQ-025 SHALL implement FSM IDLE/FLUSH: flush in IDLE -> FLUSH with sweep pointer = 0; FLUSH writes INIT_CTR to one entry per cycle; at pointer = 2^INDEX_BITS-1 the FSM writes that entry and returns to IDLE.
REQ-026 SHALL assert busy in every FLUSH cycle; a flush sweep takes exactly 2^INDEX_BITS cycles.
REQ-027 SHALL, while busy, drop updates (no counter, GHR or mispredict_cnt change) and answer lookups with prediction 0 and pred_valid 1.
REQ-028 SHALL clear GHR at flush entry; mispredict_cnt SHALL NOT be cleared by flush.
REQ-029 SHALL ignore flush asserted while already in FLUSH; the sweep does not restart.

Reset
REQ-030 SHALL, while rst_n = 0, asynchronously set all counters to INIT_CTR, GHR to 0, FSM to IDLE, sweep pointer to 0, pred_valid 0, prediction 0, busy 0 and mispredict_cnt 0.
REQ-031 SHALL abort an in-progress flush when reset is asserted mid-sweep; after release the block is in IDLE with every entry at INIT_CTR.

Verification
REQ-032 SHALL cover saturation: MODE 0, pc 0x40, outcomes T,T,T,T -> predictions after each update are 0,1,1,1; then N,N -> 1,0.
REQ-033 SHALL cover forwarding: counter at 1, same-cycle lookup and update of pc 0x40 with outcome T -> prediction 1 the next cycle.
REQ-034 SHALL cover gshare aliasing: MODE 1, GHR = 6'b000011, update of pc 0x0C trains index 0; a lookup of pc 0x0C after the GHR shift uses a different entry.
REQ-035 SHALL cover flush: flush at INDEX_BITS = 6 -> busy for exactly 64 cycles, updates ignored, all entries at INIT_CTR afterward, mispredict_cnt unchanged.
REQ-036 SHALL cover reset mid-flush and mispredict_cnt saturation: preload the count to 16'hFFFE, two mispredicts -> 16'hFFFF; rst_n low -> count 0 and busy 0.
